fetch_buffer: RTL and testbench

Stage-1 instruction fetch buffer between the program counter and the stage-2 decoder. Issues each PC value to the instruction memory over a valid/ready request channel and collects in-order responses into a small queue. Presents instructions with their PCs to decode through a valid/ready handshake. Back-pressures the PC through `pc_stall` and discards stale responses on a branch/jump redirect.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_buffer.sv | 153 +++++++++++++++
 tb/tb_fetch_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the stage-1 fetch buffer: reset PC, NOP encoding,
// FSM state encoding and the queued {pc, inst} entry.
package fetch_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_1000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, push/pop, full/empty and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over a same-cycle push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Stage-1 fetch buffer: issues PCs to instruction memory, queues in-order
// responses with their PCs for decode, and squashes stale responses after a
// redirect. Optional combinational response bypass: FETCH_BYPASS_EN.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   pc_in,
  input  logic          redirect,
  output logic          imem_req_valid,
  output logic [31:0]   imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_resp_valid,
  input  logic [31:0]   imem_resp_data,
  output logic          inst_valid,
  output logic [31:0]   inst_data,
  output logic [31:0]   inst_pc,
  input  logic          inst_ready,
  output logic          pc_stall,
  output logic [0:0]    dbg_state,
  output logic [CW-1:0] dbg_outstanding,
  output logic [CW-1:0] dbg_count,
  output logic [CW-1:0] dbg_kill_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and the response channel has no ready.

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic [0:0]    state_q, state_d;

  logic          in_run;
  logic          resp_take;
  logic          resp_live;
  logic          req_fire;
  logic          deq;
  logic          bypass;
  logic [CW:0]   occ;

  logic [31:0]   pcq_head;
  logic          pcq_full, pcq_empty;
  logic [CW-1:0] pcq_count;

  fetch_entry_t  resp_entry;
  fetch_entry_t  iq_head;
  logic          iq_push, iq_pop;
  logic          iq_full, iq_empty;
  logic [CW-1:0] iq_count;

  logic          unused_fifo_flags;

  assign in_run    = (state_q == ST_RUN);
  // A response with nothing in flight can only be a pre-reset leftover.
  assign resp_take = imem_resp_valid && (outstanding_q != '0);
  assign resp_live = resp_take && in_run && !redirect;

  assign resp_entry = '{pc: pcq_head, inst: imem_resp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_live && iq_empty;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = !redirect && (!iq_empty || bypass);
  assign inst_data  = bypass ? imem_resp_data : iq_head.inst;
  assign inst_pc    = bypass ? pcq_head : iq_head.pc;
  assign deq        = inst_valid && inst_ready;

  assign iq_push = resp_live && !(bypass && inst_ready);
  assign iq_pop  = deq && !bypass;

  // Credits still held after this cycle's dequeue decide whether to issue.
  assign occ = {1'b0, outstanding_q} + {1'b0, iq_count} - {{CW{1'b0}}, deq};

  assign imem_req_valid = reset_n && !redirect && in_run && (occ < DEPTH_C);
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_stall       = !req_fire;

  fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (pc_in),
    .pop       (resp_live),
    .pop_data  (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (iq_push),
    .push_data (resp_entry),
    .pop       (iq_pop),
    .pop_data  (iq_head),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (iq_count)
  );

  assign unused_fifo_flags = &{1'b0, pcq_full, pcq_empty, pcq_count, iq_full};

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_take);
    kill_cnt_d    = kill_cnt_q;
    state_d       = state_q;
    if (in_run) begin
      if (redirect) begin
        kill_cnt_d = outstanding_q - CW'(resp_take);
        state_d    = (kill_cnt_d != '0) ? ST_DRAIN : ST_RUN;
      end
    end else begin
      // A second redirect while draining only flushes the queues.
      if (resp_take) begin
        kill_cnt_d = kill_cnt_q - CW'(1);
      end
      if (kill_cnt_d == '0) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      state_q       <= ST_RUN;
    end else begin
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      state_q       <= state_d;
    end
  end

  assign dbg_state       = state_q;
  assign dbg_outstanding = outstanding_q;
  assign dbg_count       = iq_count;
  assign dbg_kill_cnt    = kill_cnt_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: in-order memory model with random latency and a
// request-order scoreboard of PCs that must reach decode.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset_n;
  logic [31:0]   pc_in;
  logic          redirect;
  logic          imem_req_valid;
  logic [31:0]   imem_req_addr;
  logic          imem_req_ready;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_ready;
  logic          pc_stall;
  logic [0:0]    dbg_state;
  logic [CW-1:0] dbg_outstanding;
  logic [CW-1:0] dbg_count;
  logic [CW-1:0] dbg_kill_cnt;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pc_in           (pc_in),
    .redirect        (redirect),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .pc_stall        (pc_stall),
    .dbg_state       (dbg_state),
    .dbg_outstanding (dbg_outstanding),
    .dbg_count       (dbg_count),
    .dbg_kill_cnt    (dbg_kill_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          killed;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          n_arrived;
  logic [31:0] model_pc;
  int          lat_min, lat_max;
  int          cyc;
  int          deq_cnt;
  logic [31:0] last_deq_pc;
  int          first_deq_cyc;
  int          checks, errors;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic int killed_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].killed) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit req_rdy, input bit inst_rdy, input bit redir,
                      input logic [31:0] tgt);
    bit resp_now, resp_killed, draining, bypass_hit, exp_iv, exp_req, deq;
    int occ, due;
    @(negedge clk);
    chk("outstanding", 32'(dbg_outstanding), mem_q.size());
    chk("count", 32'(dbg_count), n_arrived);
    chk("kill_cnt", 32'(dbg_kill_cnt), killed_cnt());
    draining = (killed_cnt() > 0);
    chk("state", 32'(dbg_state), 32'(draining));
    resp_now    = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    resp_killed = resp_now && mem_q[0].killed;
    pc_in           = model_pc;
    imem_req_ready  = req_rdy;
    inst_ready      = inst_rdy;
    redirect        = redir;
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? imem_word(mem_q[0].addr) : $urandom;
    #1;
    bypass_hit = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass_hit = resp_now && !resp_killed && !redir && (n_arrived == 0);
`endif
    exp_iv = !redir && ((n_arrived > 0) || bypass_hit);
    chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
    deq = exp_iv && inst_rdy;
    occ = mem_q.size() + n_arrived - int'(deq);
    exp_req = !redir && !draining && (occ < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    chk("req_addr", imem_req_addr, model_pc);
    chk("pc_stall", 32'(pc_stall), 32'(!(exp_req && req_rdy)));
    chk("resp_room", 32'(imem_resp_valid && (dbg_count == CW'(DEPTH))), 32'd0);
    if (deq && exp_q.size() > 0) begin
      chk("inst_pc", inst_pc, exp_q[0]);
      chk("inst_data", inst_data, imem_word(exp_q[0]));
      last_deq_pc = exp_q[0];
      if (first_deq_cyc < 0) first_deq_cyc = cyc;
      deq_cnt++;
      void'(exp_q.pop_front());
      n_arrived--;
    end
    if (resp_now) begin
      void'(mem_q.pop_front());
      if (!resp_killed && !redir) n_arrived++;
    end
    if (redir) begin
      exp_q.delete();
      n_arrived = 0;
      foreach (mem_q[i]) mem_q[i].killed = 1'b1;
      model_pc = tgt;
    end else if (exp_req && req_rdy) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
      exp_q.push_back(model_pc);
      mem_q.push_back('{addr: model_pc, due: due, killed: 1'b0});
      model_pc = model_pc + 32'd4;
    end
    cyc++;
  endtask

  // ---------------- asynchronous reset ----------------
  task automatic apply_reset();
    #2 reset_n = 1'b0;
    redirect = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; pc_in = PC_RESET;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd1);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_counters", 32'({dbg_outstanding, dbg_count, dbg_kill_cnt, dbg_state}), 32'd0);
    mem_q.delete(); exp_q.delete();
    n_arrived = 0; model_pc = PC_RESET; first_deq_cyc = -1; deq_cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int start_cyc;
    bit found;
    logic [31:0] held_pc;
    checks = 0; errors = 0; cyc = 0;
    lat_min = 1; lat_max = 1;
    reset_n = 1'b0;
    apply_reset();

    // Streaming from PC_RESET with 1-cycle memory
    start_cyc = cyc;
    repeat (6) step(1, 1, 0, '0);
`ifdef FETCH_BYPASS_EN
    chk("first_latency", first_deq_cyc - start_cyc, 1);
    chk("stream_deqs", deq_cnt, 5);
`else
    chk("first_latency", first_deq_cyc - start_cyc, 2);
    chk("stream_deqs", deq_cnt, 4);
`endif
    chk("stream_last_pc", last_deq_pc, PC_RESET + 32'(4 * (deq_cnt - 1)));

    // Decode stalled for 5 cycles: queue fills, PC held
    repeat (5) step(1, 0, 0, '0);
    #5;
    chk("full_count", 32'(dbg_count), DEPTH);
    chk("full_stall", 32'(pc_stall), 32'd1);
    repeat (6) step(1, 1, 0, '0);

    // Memory refuses requests for 3 cycles
    held_pc = model_pc;
    repeat (3) begin
      step(0, 1, 0, '0);
      chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
      chk("hold_pc", imem_req_addr, held_pc);
    end
    repeat (4) step(1, 1, 0, '0);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    repeat (6) step(1, 1, 0, '0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 2 && mem_q[0].due > cyc) begin
        step(1, 1, 1, 32'h0000_0100);
        found = 1;
      end else begin
        step(1, 1, 0, '0);
      end
    end
    chk("redir2_found", 32'(found), 32'd1);
    step(1, 1, 0, '0);
    chk("redir2_kill", 32'(dbg_kill_cnt), 32'd2);
    start_cyc = deq_cnt;
    for (int i = 0; i < 30 && deq_cnt == start_cyc; i++) step(1, 1, 0, '0);
    chk("redir2_first_pc", last_deq_pc, 32'h0000_0100);

    // Redirect in the same cycle as a response
    lat_min = 2; lat_max = 2;
    repeat (6) step(1, 1, 0, '0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 2 && mem_q[0].due <= cyc) begin
        step(1, 1, 1, 32'h0000_0200);
        found = 1;
      end else begin
        step(1, 1, 0, '0);
      end
    end
    chk("redir1_found", 32'(found), 32'd1);
    step(1, 1, 0, '0);
    chk("redir1_kill", 32'(dbg_kill_cnt), 32'd1);
    start_cyc = deq_cnt;
    for (int i = 0; i < 30 && deq_cnt == start_cyc; i++) step(1, 1, 0, '0);
    chk("redir1_first_pc", last_deq_pc, 32'h0000_0200);

    // Random traffic
    lat_min = 1; lat_max = 4;
    repeat (400) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0,
           32'h0000_4000 + 32'($urandom_range(0, 255)) * 32'd4);
    end

    // Reset mid-stream with the queue full
    lat_min = 1; lat_max = 1;
    repeat (4) step(1, 1, 0, '0);
    repeat (4) step(1, 0, 0, '0);
    apply_reset();
    repeat (8) step(1, 1, 0, '0);
    chk("restart_deqs", 32'(deq_cnt > 0), 32'd1);
    chk("restart_pc", exp_q.size() > 0 ? last_deq_pc - 32'(4 * (deq_cnt - 1)) : last_deq_pc, PC_RESET);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
